// File: rtl/sbox_sched_pkg.sv
// ============================================================================
// sbox_sched_pkg : shared constants and FSM state type for the S-box word scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package sbox_sched_pkg;

    localparam int NBYTES        = 4;
    localparam int IDX_W         = 2;
    localparam int BITS_PER_BYTE = 8;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sbox_tok_pipe.sv
// ============================================================================
// sbox_tok_pipe : free-running {valid, idx} shift line matching the S-box depth
// Rev 1.0
// ============================================================================
`default_nettype none

module sbox_tok_pipe #(
    parameter int OUT_LAT = 4,
    parameter int IDX_W   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tok_valid_i,
    input  logic [IDX_W-1:0] tok_idx_i,
    output logic             tok_valid_o,
    output logic [IDX_W-1:0] tok_idx_o
);

    logic [OUT_LAT-1:0]            vld_q;
    logic [OUT_LAT-1:0][IDX_W-1:0] idx_q;

    // Advances every cycle: the S-box it shadows has no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= tok_valid_i;
            idx_q[0] <= tok_idx_i;
            for (int s = 1; s < OUT_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                idx_q[s] <= idx_q[s-1];
            end
        end
    end

    assign tok_valid_o = vld_q[OUT_LAT-1];
    assign tok_idx_o   = idx_q[OUT_LAT-1];

endmodule

`default_nettype wire

// File: rtl/sbox_word_sched.sv
// ============================================================================
// sbox_word_sched : feeds one masked 32-bit word bytewise through a shared S-box
// Rev 1.0
// ============================================================================
`default_nettype none

module sbox_word_sched
    import sbox_sched_pkg::*;
#(
    parameter int D       = 2,
    parameter int OUT_LAT = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BITS_PER_BYTE*NBYTES*D-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [BITS_PER_BYTE*NBYTES*D-1:0] out_data,
    output logic [BITS_PER_BYTE*D-1:0]        sb_in,
    input  logic [BITS_PER_BYTE*D-1:0]        sb_out,
    input  logic                              rnd_valid,
    output logic                              rnd_ready,
    output logic                              busy
);

    localparam int BYTE_W = BITS_PER_BYTE * D;
    localparam int WORD_W = NBYTES * BYTE_W;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [WORD_W-1:0]   word_q;
    logic [WORD_W-1:0]   out_data_q;
    logic [WORD_W-1:0]   out_data_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic                inject;
    logic                cap_valid;
    logic [IDX_W-1:0]    cap_idx;

    assign inject    = (state_q == FEED) && rnd_valid;
    assign rnd_ready = inject;
    // Idle S-box slots see all-zero shares so no stale mask toggles the datapath.
    assign sb_in     = inject ? word_q[int'(cnt_q)*BYTE_W +: BYTE_W] : '0;

    sbox_tok_pipe #(
        .OUT_LAT (OUT_LAT),
        .IDX_W   (IDX_W)
    ) u_tok_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tok_valid_i (inject),
        .tok_idx_i   (cnt_q),
        .tok_valid_o (cap_valid),
        .tok_idx_o   (cap_idx)
    );

    always_comb begin
        out_data_d = out_data_q;
        if (cap_valid) begin
            out_data_d[int'(cap_idx)*BYTE_W +: BYTE_W] = sb_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else begin
            out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= FEED;
                        cnt_q      <= '0;
                        word_q     <= in_data;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                FEED: begin
                    if (inject) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Byte order is preserved, so the last index is the last capture.
                    if (cap_valid && (cap_idx == LAST_IDX)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sbox_word_sched.sv
// ============================================================================
// tb_sbox_word_sched : directed table plus randomized words against an AES S-box model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sbox_word_sched;

    localparam int D       = 2;
    localparam int OUT_LAT = 4;
    localparam int BW      = 8 * D;
    localparam int WW      = 4 * BW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WW-1:0] out_data;
    logic [BW-1:0] sb_in;
    logic [BW-1:0] sb_out;
    logic          rnd_valid = 1'b0;
    logic          rnd_ready;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sbox_word_sched #(.D(D), .OUT_LAT(OUT_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sb_in     (sb_in),
        .sb_out    (sb_out),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy)
    );

    // ---------------- AES S-box reference (GF(2^8) inverse + affine) ----------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [BW-1:0] mask_byte(input logic [7:0] v, input logic [7:0] m);
        logic [BW-1:0] r = '0;
        for (int j = 0; j < 8; j++) begin
            r[j*D]     = v[j] ^ m[j];
            r[j*D + 1] = m[j];
        end
        return r;
    endfunction

    function automatic logic [7:0] unmask_byte(input logic [BW-1:0] s);
        logic [7:0] v = '0;
        for (int j = 0; j < 8; j++) v[j] = ^s[j*D +: D];
        return v;
    endfunction

    function automatic logic [WW-1:0] mask_word(input logic [31:0] w, input logic [31:0] m);
        logic [WW-1:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*BW +: BW] = mask_byte(w[k*8 +: 8], m[k*8 +: 8]);
        return r;
    endfunction

    function automatic logic [31:0] unmask_word(input logic [WW-1:0] s);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = unmask_byte(s[k*BW +: BW]);
        return w;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] w);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = aes_sbox(w[k*8 +: 8]);
        return r;
    endfunction

    // Output rises OUT_LAT cycles after the cycle holding the fourth randomness-valid.
    function automatic int model_lat(input logic [31:0] pat);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (pat[i]) n++;
            if (n == 4) return i + 1 + OUT_LAT;
        end
        return -1;
    endfunction

    // Free-running pipelined masked S-box, freshly remasked on entry.
    logic [BW-1:0] sb_pipe [OUT_LAT] = '{default: '0};
    always @(posedge clk) begin
        for (int s = OUT_LAT - 1; s > 0; s--) sb_pipe[s] <= sb_pipe[s-1];
        sb_pipe[0] <= mask_byte(aes_sbox(unmask_byte(sb_in)), 8'($urandom));
    end
    assign sb_out = sb_pipe[OUT_LAT-1];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the out handshake.
    task automatic do_word(input string nm, input logic [31:0] w, input logic [31:0] m,
                           input logic [31:0] pat, input int hold, input bit pre_ready,
                           input bit junk, input logic [31:0] exp_w, input int exp_lat);
        int lat = -1;
        int pulses = 0;
        bit rr_bad = 0;
        bit st_bad = 0;
        bit hold_bad = 0;
        logic exp_rr;
        logic [WW-1:0] snap;
        check({nm, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_data   = mask_word(w, m);
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 64 && lat < 0; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
            end else begin
                in_valid  = junk;
                in_data   = junk ? mask_word(32'hDEADBEEF, 32'h12345678) : '0;
                rnd_valid = (i < 32) ? pat[i] : 1'b1;
                out_ready = pre_ready;
                #1;
                exp_rr = (pulses < 4) ? rnd_valid : 1'b0;
                if (rnd_ready !== exp_rr) rr_bad = 1;
                if (rnd_ready === 1'b1) pulses++;
                if (in_ready !== 1'b0 || busy !== 1'b1) st_bad = 1;
            end
        end
        out_ready = 1'b0;
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_data"}, 64'(unmask_word(out_data)), 64'(exp_w));
        check({nm, "_rnd_ready"}, {62'd0, rr_bad, 1'b0} | 64'(pulses), 64'd4);
        check({nm, "_busy_flags"}, 64'(st_bad), 64'd0);
        snap = out_data;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== snap || in_ready !== 1'b0) hold_bad = 1;
            end
            check({nm, "_hold_stable"}, 64'(hold_bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({nm, "_post_handshake"}, {61'd0, out_valid, busy, in_ready}, 64'b001);
    endtask

    typedef struct {
        string       nm;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] pat;
        int          hold;
        bit          pre_ready;
        bit          junk;
        logic [31:0] exp_w;
        int          exp_lat;
    } vec_t;

    vec_t vecs [5];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rw, rm, rp;
        vecs[0] = '{"basic",   32'hFF530100, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h16ED7C63, 8};
        vecs[1] = '{"stall",   32'hFF530100, 32'hA5A5A5A5, 32'hFFFFFFF5, 0, 1'b0, 1'b0, 32'h16ED7C63, 10};
        vecs[2] = '{"hold",    32'hFF530100, 32'h5AC3A53C, 32'hFFFFFFFF, 5, 1'b0, 1'b1, 32'h16ED7C63, 8};
        vecs[3] = '{"b2b_a",   32'h00000000, 32'h3C3C3C3C, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h63636363, 8};
        vecs[4] = '{"b2b_b",   32'h53535353, 32'hF00FF00F, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'hEDEDEDED, 8};

        rnd_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {60'd0, out_valid, rnd_ready, busy, 1'b0}, 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        rst_n     = 1'b1;
        rnd_valid = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 5; v++) begin
            do_word(vecs[v].nm, vecs[v].word, vecs[v].mask, vecs[v].pat, vecs[v].hold,
                    vecs[v].pre_ready, vecs[v].junk, vecs[v].exp_w, vecs[v].exp_lat);
        end

        // Reset while bytes are still in flight in DRAIN.
        in_valid  = 1'b1;
        in_data   = mask_word(32'h53535353, 32'h99669966);
        @(posedge clk);
        in_valid  = 1'b0;
        rnd_valid = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {61'd0, out_valid, busy, rnd_ready}, 64'd0);
        check("midreset_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rnd_valid = 1'b0;
        begin
            bit stale = 0;
            for (int c = 0; c < OUT_LAT + 2; c++) begin
                @(negedge clk);
                if (out_data !== '0 || busy !== 1'b0 || out_valid !== 1'b0) stale = 1;
            end
            check("midreset_no_stale", 64'(stale), 64'd0);
        end
        do_word("after_reset", 32'h01010101, 32'h0F1E2D3C, 32'hFFFFFFFF, 0, 1'b0, 1'b0,
                32'h7C7C7C7C, 8);

        for (int r = 0; r < 8; r++) begin
            rw = $urandom;
            rm = $urandom;
            rp = $urandom | 32'hFFFF0000;
            do_word("random", rw, rm, rp, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), model_word(rw), model_lat(rp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
